// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer: state encoding doubles as the phase code.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    SHR   = 2'd2,
    SHL   = 2'd3
  } state_e;

  localparam logic [7:0] LED_OFF = 8'h00;
  localparam logic [7:0] LED_ALL = 8'hFF;
  localparam logic [7:0] LED_MSB = 8'h80;
  localparam logic [7:0] LED_LSB = 8'h01;

  localparam int unsigned STEP_W = 4;

endpackage

// File: rtl/led_tick_gen.sv
// Step-enable generator: one-cycle tick every (TICK_DIV >> speed_sel) clk cycles while enabled.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed_sel,
  output logic       tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] last_q, last_d;
  logic [CW-1:0] sel_last;

  assign sel_last = CW'((TICK_DIV >> speed_sel) - 32'd1);
  assign tick     = en && (cnt_q == last_q);

  // Period is latched only on clear or wrap so a speed change never cuts a period short.
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (clr || !en) begin
      cnt_d = '0;
      if (clr) begin
        last_d = sel_last;
      end
    end else if (tick) begin
      cnt_d  = '0;
      last_d = sel_last;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      last_q <= CW'(TICK_DIV - 32'd1);
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Run/stop controller and BLINK -> SHR -> SHL step scheduler for the 8-bit LED pattern.
// Optional auto-stop after N_CYCLES full cycles: define LED_SEQ_REPEAT_LIMIT_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned BLINK_TICKS = 6,
  parameter int unsigned SHIFT_TICKS = 8,
  parameter int unsigned N_CYCLES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] speed_sel,
  output logic [7:0] LED,
  output logic       busy,
  output logic [1:0] phase,
  output logic       cycle_done
);

  localparam logic [STEP_W-1:0] BLINK_LAST = STEP_W'(BLINK_TICKS - 1);
  localparam logic [STEP_W-1:0] SHIFT_LAST = STEP_W'(SHIFT_TICKS - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        led_q, led_d;
  logic              done_q, done_d;
  logic              tick;
  logic              go;

`ifdef LED_SEQ_REPEAT_LIMIT_EN
  localparam logic [3:0] CYC_LAST = 4'(N_CYCLES - 1);
  logic [3:0] cyc_q, cyc_d;
`endif

  assign go = start && !stop && (state_q == IDLE);

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .en        (state_q != IDLE),
    .clr       (go || stop),
    .speed_sel (speed_sel),
    .tick      (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      led_q   <= LED_OFF;
      done_q  <= 1'b0;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      led_q   <= led_d;
      done_q  <= done_d;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    led_d   = led_q;
    done_d  = 1'b0;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
    cyc_d   = cyc_q;
`endif
    unique case (state_q)
      IDLE: begin
        led_d = LED_OFF;
        if (go) begin
          state_d = BLINK;
          step_d  = '0;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
          cyc_d   = '0;
`endif
        end
      end
      BLINK: begin
        if (tick) begin
          led_d = step_q[0] ? LED_OFF : LED_ALL;
          if (step_q == BLINK_LAST) begin
            state_d = SHR;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      SHR: begin
        if (tick) begin
          led_d = (step_q == '0) ? LED_MSB : {1'b0, led_q[7:1]};
          if (step_q == SHIFT_LAST) begin
            state_d = SHL;
            step_d  = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      SHL: begin
        if (tick) begin
          led_d = (step_q == '0) ? LED_LSB : {led_q[6:0], 1'b0};
          if (step_q == SHIFT_LAST) begin
            state_d = BLINK;
            step_d  = '0;
            done_d  = 1'b1;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
            cyc_d = cyc_q + 4'd1;
            if (cyc_q == CYC_LAST) begin
              state_d = IDLE;
              led_d   = LED_OFF;
              cyc_d   = '0;
            end
`endif
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Stop overrides everything, including a coinciding tick and its cycle_done.
    if (stop) begin
      state_d = IDLE;
      step_d  = '0;
      led_d   = LED_OFF;
      done_d  = 1'b0;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
      cyc_d   = '0;
`endif
    end
  end

  always_comb begin
    busy       = (state_q != IDLE);
    phase      = state_q;
    LED        = led_q;
    cycle_done = done_q;
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: stimulus queues expected per-tick outputs, a monitor checks them.
module tb_led_seq_ctrl;

  typedef struct {
    int         stamp;
    logic [7:0] led;
    logic [1:0] ph;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [1:0] speed_sel;
  logic [7:0] LED;
  logic       busy;
  logic [1:0] phase;
  logic       cycle_done;

  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  logic pend = 1'b0;
  exp_t q[$];

  logic [7:0] led_tab [22];
  logic [1:0] ph_tab  [22];

  led_seq_ctrl #(
    .TICK_DIV    (16),
    .BLINK_TICKS (6),
    .SHIFT_TICKS (8),
    .N_CYCLES    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .speed_sel  (speed_sel),
    .LED        (LED),
    .busy       (busy),
    .phase      (phase),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A tick seen mid-cycle means the outputs after the next edge are a scored result.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      vectors++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cyc %0d LED %h phase %0d, want no tick", cyc, LED, phase);
      end else begin
        e = q.pop_front();
        if (cyc != e.stamp || LED !== e.led || phase !== e.ph || busy !== (e.ph != 2'd0)
            || cycle_done !== e.done) begin
          errors++;
          $display("FAIL tick_out: got cyc %0d LED %h phase %0d busy %b done %b, want cyc %0d LED %h phase %0d busy %b done %b",
                   cyc, LED, phase, busy, cycle_done, e.stamp, e.led, e.ph, e.ph != 2'd0, e.done);
        end
      end
    end else if (cycle_done !== 1'b0) begin
      vectors++;
      errors++;
      $display("FAIL spurious_done: got cycle_done %b at cyc %0d, want 0", cycle_done, cyc);
    end
    pend = dut.u_tick.tick;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int s, input int p, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.stamp = s + 1 + p * (k + 1);
      e.led   = led_tab[k % 22];
      e.ph    = ph_tab[k % 22];
      e.done  = ((k % 22) == 21);
      q.push_back(e);
    end
  endtask

  task automatic push_one(input int stamp, input logic [7:0] led, input logic [1:0] ph,
                          input logic done);
    exp_t e;
    e.stamp = stamp;
    e.led   = led;
    e.ph    = ph;
    e.done  = done;
    q.push_back(e);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (LED !== 8'h00 || busy !== 1'b0 || phase !== 2'd0 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL %s: got LED %h busy %b phase %0d done %b, want LED 00 busy 0 phase 0 done 0",
               name, LED, busy, phase, cycle_done);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending ticks after %0d cycles, want 0", name, q.size(), budget);
      q.delete();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop(input string name);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_idle(name);
  endtask

  initial begin
    int   s;
    exp_t e;
    led_tab = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00,
                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    ph_tab  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3,
                2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    speed_sel = 2'd0;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;
    repeat (2) step();
    check_idle("idle_after_reset");

    // Full sequence at speed 0, with a start pulse during BLINK that must be ignored.
    s = cyc;
`ifdef LED_SEQ_REPEAT_LIMIT_EN
    push_run(s, 16, 44);
    e = q.pop_back();
    e.led = 8'h00;
    e.ph  = 2'd0;
    q.push_back(e);
`else
    push_run(s, 16, 45);
`endif
    pulse_start();
    repeat (30) step();
    pulse_start();
    wait_drain("full_run", 800);
`ifdef LED_SEQ_REPEAT_LIMIT_EN
    repeat (40) step();
    check_idle("auto_stop");
`else
    pulse_stop("stop_after_run");
`endif
    repeat (3) step();

    // Stop on the same cycle as the 10th tick.
    s = cyc;
    push_run(s, 16, 9);
    push_one(s + 161, 8'h00, 2'd0, 1'b0);
    pulse_start();
    while (cyc < s + 160) step();
    pulse_stop("stop_on_tick");
    wait_drain("stop_on_tick", 10);
    repeat (20) step();
    check_idle("idle_after_stop");

    s = cyc;
    push_run(s, 16, 1);
    pulse_start();
    wait_drain("restart", 40);
    pulse_stop("stop_after_restart");

    // start and stop together from IDLE.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check_idle("start_stop_same");
    repeat (40) step();
    check_idle("still_idle");

    // Speed 2, then change to 0 mid-period: applies only after the current wrap.
    speed_sel = 2'd2;
    s = cyc;
    push_one(s + 5, 8'hFF, 2'd1, 1'b0);
    push_one(s + 9, 8'h00, 2'd1, 1'b0);
    push_one(s + 25, 8'hFF, 2'd1, 1'b0);
    pulse_start();
    while (cyc < s + 7) step();
    speed_sel = 2'd0;
    wait_drain("speed_change", 100);
    pulse_stop("stop_after_speed");

    // Async reset between edges in SHL.
    speed_sel = 2'd2;
    s = cyc;
    push_run(s, 4, 16);
    pulse_start();
    while (cyc < s + 67) step();
    #2;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pre_rst_ticks: got %0d pending, want 0", q.size());
      q.delete();
    end
    step();
    rst = 1'b0;
    speed_sel = 2'd0;
    repeat (20) step();
    check_idle("idle_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
- Run/stop controller and step scheduler for the 8-bit LED pattern datapath on the board.
- Generates its own step-enable tick from the system clock; no derived clocks.
- Sequences three phases in a fixed loop: BLINK, then SHR (shift right), then SHL (shift left).
- Exposes busy, phase and cycle-done status for the top level and the display logic.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per step at speed_sel=0. Must be ≥ 16.
- BLINK_TICKS, 6: number of steps in the BLINK phase.
- SHIFT_TICKS, 8: number of steps in each of the SHR and SHL phases.
- N_CYCLES, 3: full cycles before auto-stop. Used only with LED_SEQ_REPEAT_LIMIT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins sequencing from IDLE
- stop  in  1  one-cycle pulse; aborts to IDLE
- speed_sel  in  2  step period = TICK_DIV >> speed_sel
- LED  out  8  pattern output, registered
- busy  out  1  high in any state except IDLE
- phase  out  2  0=IDLE, 1=BLINK, 2=SHR, 3=SHL
- cycle_done  out  1  one-cycle pulse at the end of each full cycle

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: LED=8'h00, busy=0, phase=0, cycle_done=0, state=IDLE, step counter=0, tick divider=0.
- All state changes occur on posedge clk.
- Tick divider:
  - Counts clk cycles only while busy.
  - Issues a one-cycle tick when count = (TICK_DIV>>speed_sel)-1, then wraps to 0.
  - speed_sel is sampled only at wrap, so a change never truncates a period in progress.
- IDLE:
  - LED held at 8'h00.
  - start → BLINK. Divider and step counter cleared.
  - First tick arrives exactly TICK_DIV>>speed_sel cycles after the start cycle.
- BLINK, on tick k (k=0..BLINK_TICKS-1):
  - LED = 8'hFF when k is even, 8'h00 when k is odd.
  - After k=BLINK_TICKS-1, the state moves to SHR.
- SHR:
  - First tick loads 8'h80.
  - Each later tick applies LED = {1'b0, LED[7:1]}.
  - After SHIFT_TICKS steps (LED ends at 8'h01), the state moves to SHL.
- SHL:
  - First tick loads 8'h01.
  - Each later tick applies LED = {LED[6:0], 1'b0}.
  - After SHIFT_TICKS steps (LED ends at 8'h80):
    - cycle_done pulses in the same cycle as that last tick's update.
    - The state moves to BLINK, step counter = 0.
- One full cycle is BLINK_TICKS + 2*SHIFT_TICKS ticks (22 at defaults).
- Between ticks, LED, state and step counter are held.
- stop:
  - From any state: next edge goes to IDLE, LED=8'h00, counters cleared.
  - cycle_done is suppressed even if a tick coincides with stop.
- start while busy: ignored.
- start and stop in the same cycle: stop wins; remains/returns to IDLE.
- Async rst mid-operation: immediate return to the reset values, with no partial tick.

Optional Feature:
- Macro: LED_SEQ_REPEAT_LIMIT_EN.
- Defined:
  - A 4-bit cycle counter increments on each cycle_done.
  - On the N_CYCLESth cycle_done, the state goes to IDLE instead of BLINK and LED=8'h00 on that same edge.
  - The cycle counter is cleared on start, stop and rst.
- Undefined:
  - No cycle counter; the sequence loops indefinitely until stop or rst.
  - N_CYCLES is ignored.

Decomposition:
- Package led_seq_pkg:
  - state enum: IDLE, BLINK, SHR, SHL, encoded to match phase.
  - Constants LED_OFF=8'h00, LED_ALL=8'hFF, LED_MSB=8'h80, LED_LSB=8'h01.
  - Step-counter width localparam.
- Sub-module led_tick_gen:
  - Parameterised divider with enable, clear and speed_sel.
  - Outputs a one-cycle tick enable (replaces the derived-clock divider style).

Test Plan:
- TICK_DIV=16, speed_sel=0: rst, then start at t0 → LED sequence, one value per tick:
  - FF,00,FF,00,FF,00
  - 80,40,20,10,08,04,02,01
  - 01,02,04,08,10,20,40,80
  - cycle_done on the 22nd tick, and the 23rd tick gives FF.
- speed_sel=2 after start → ticks every 4 cycles; change to 0 mid-period takes effect only after the current wrap.
- stop asserted on the same cycle as the 10th tick → LED=00, busy=0, phase=0 next edge, no cycle_done; a later start restarts at FF.
- start+stop in the same cycle from IDLE → stays IDLE; start during BLINK → no effect on LED/step timing.
- rst asserted asynchronously mid-SHL (between edges) → LED=00, phase=0 immediately, without waiting for a clock edge.
- With LED_SEQ_REPEAT_LIMIT_EN, N_CYCLES=2 → exactly 2 cycle_done pulses, then IDLE with LED=00; without the macro, a 3rd cycle starts with FF.
